// File: rtl/interrupt_acknowledge_sequencer.sv
// rtl/interrupt_acknowledge_sequencer.sv - CPU-side 8259 INTA# two-pulse sequencer with vector capture
module interrupt_acknowledge_sequencer #(
  parameter int INTA_LOW_CYCLES = 2,
  parameter int INTA_GAP_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       interrupt_request,
  input  logic       interrupt_enable,
  input  logic       instruction_boundary,
  input  logic [7:0] data_bus_in,
  input  logic       vector_taken,
  output logic       interrupt_acknowledge_n,
  output logic [7:0] vector,
  output logic       vector_valid,
  output logic       busy
);

  localparam int MAX_CYCLES = (INTA_LOW_CYCLES > INTA_GAP_CYCLES) ? INTA_LOW_CYCLES : INTA_GAP_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] LOW_LOAD = CW'(INTA_LOW_CYCLES);
  localparam logic [CW-1:0] GAP_LOAD = CW'(INTA_GAP_CYCLES);
  localparam logic [CW-1:0] ONE      = CW'(1);

  typedef enum logic [2:0] {IDLE, INTA1, GAP, INTA2, HOLD} state_t;

  state_t        state, state_next;
  logic [CW-1:0] count, count_next;
  logic          capture;
  logic          expired;

  assign expired = (count == ONE);

  // Counter is loaded on state entry and the state is left on the edge where it reads one.
  always_comb begin
    state_next = state;
    count_next = count;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (interrupt_request && interrupt_enable && instruction_boundary) begin
          state_next = INTA1;
          count_next = LOW_LOAD;
        end
      end
      INTA1: begin
        if (expired) begin
          state_next = GAP;
          count_next = GAP_LOAD;
        end else begin
          count_next = count - ONE;
        end
      end
      GAP: begin
        if (expired) begin
          state_next = INTA2;
          count_next = LOW_LOAD;
        end else begin
          count_next = count - ONE;
        end
      end
      INTA2: begin
        if (expired) begin
          state_next = HOLD;
          capture    = 1'b1;
        end else begin
          count_next = count - ONE;
        end
      end
      HOLD: begin
        if (vector_taken) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs come straight from flops decoded off the next state, so INTA# cannot glitch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                   <= IDLE;
      count                   <= '0;
      interrupt_acknowledge_n <= 1'b1;
      vector                  <= 8'h00;
      vector_valid            <= 1'b0;
      busy                    <= 1'b0;
    end else begin
      state                   <= state_next;
      count                   <= count_next;
      interrupt_acknowledge_n <= !((state_next == INTA1) || (state_next == INTA2));
      vector_valid            <= (state_next == HOLD);
      busy                    <= (state_next != IDLE);
      if (capture) vector <= data_bus_in;
    end
  end

endmodule

// File: tb/tb_interrupt_acknowledge_sequencer.sv
// tb/tb_interrupt_acknowledge_sequencer.sv - directed-vector bench for interrupt_acknowledge_sequencer
module tb_interrupt_acknowledge_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] req;
  logic       enable;
  logic       boundary;
  logic [7:0] data;
  logic       taken;
  logic [2:0] inta_w;
  logic [2:0] valid_w;
  logic [2:0] busy_w;
  logic [7:0] vec_w [3];

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  interrupt_acknowledge_sequencer #(.INTA_LOW_CYCLES(2), .INTA_GAP_CYCLES(2)) dut0 (
    .clock(clock), .reset(reset), .interrupt_request(req[0]), .interrupt_enable(enable),
    .instruction_boundary(boundary), .data_bus_in(data), .vector_taken(taken),
    .interrupt_acknowledge_n(inta_w[0]), .vector(vec_w[0]), .vector_valid(valid_w[0]), .busy(busy_w[0]));

  interrupt_acknowledge_sequencer #(.INTA_LOW_CYCLES(1), .INTA_GAP_CYCLES(1)) dut1 (
    .clock(clock), .reset(reset), .interrupt_request(req[1]), .interrupt_enable(enable),
    .instruction_boundary(boundary), .data_bus_in(data), .vector_taken(taken),
    .interrupt_acknowledge_n(inta_w[1]), .vector(vec_w[1]), .vector_valid(valid_w[1]), .busy(busy_w[1]));

  interrupt_acknowledge_sequencer #(.INTA_LOW_CYCLES(3), .INTA_GAP_CYCLES(4)) dut2 (
    .clock(clock), .reset(reset), .interrupt_request(req[2]), .interrupt_enable(enable),
    .instruction_boundary(boundary), .data_bus_in(data), .vector_taken(taken),
    .interrupt_acknowledge_n(inta_w[2]), .vector(vec_w[2]), .vector_valid(valid_w[2]), .busy(busy_w[2]));

  // Starts a sequence on instance idx; j counts negedges after the start edge E0.
  task automatic run_seq(input int idx, input int l, input int g, input logic [7:0] v,
                         input logic hold_taken, input bit keep_req);
    int last;
    logic exp_inta;
    last = 2 * l + g + 1;
    @(negedge clock);
    req[idx] = 1'b1;
    enable   = 1'b1;
    boundary = 1'b1;
    taken    = hold_taken;
    data     = 8'hEE;
    for (int j = 1; j <= last + (hold_taken ? 1 : 0); j++) begin
      @(negedge clock);
      exp_inta = !((j <= l) || ((j > l + g) && (j <= 2 * l + g)));
      if (j > last) exp_inta = 1'b1;
      n_vec++;
      if (inta_w[idx] !== exp_inta) begin
        n_err++;
        $display("FAIL inta_n inst%0d j=%0d got %b want %b", idx, j, inta_w[idx], exp_inta);
      end
      n_vec++;
      if (busy_w[idx] !== (j <= last)) begin
        n_err++;
        $display("FAIL busy inst%0d j=%0d got %b want %b", idx, j, busy_w[idx], (j <= last));
      end
      n_vec++;
      if (valid_w[idx] !== (j == last)) begin
        n_err++;
        $display("FAIL vector_valid inst%0d j=%0d got %b want %b", idx, j, valid_w[idx], (j == last));
      end
      if (j == last) begin
        n_vec++;
        if (vec_w[idx] !== v) begin
          n_err++;
          $display("FAIL vector inst%0d got %h want %h", idx, vec_w[idx], v);
        end
      end
      if (!keep_req && j == l + 1) req[idx] = 1'b0;
      data = (j == 2 * l + g) ? v : 8'hEE;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; req = '0; enable = 1'b0; boundary = 1'b0; data = 8'h00; taken = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if ({inta_w[i], valid_w[i], busy_w[i], vec_w[i]} !== {3'b100, 8'h00}) begin
        n_err++;
        $display("FAIL reset_state inst%0d got inta=%b valid=%b busy=%b vec=%h want 1 0 0 00",
                 i, inta_w[i], valid_w[i], busy_w[i], vec_w[i]);
      end
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_basic;
    run_seq(0, 2, 2, 8'h08, 1'b1, 1'b0);
  endtask

  task automatic test_gating;
    @(negedge clock);
    req[0] = 1'b1; enable = 1'b0; boundary = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (k == 20) begin enable = 1'b1; boundary = 1'b0; end
      @(negedge clock);
      n_vec++;
      if (inta_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
        n_err++;
        $display("FAIL gating k=%0d got inta=%b busy=%b want 1 0", k, inta_w[0], busy_w[0]);
      end
    end
    req[0] = 1'b0;
  endtask

  task automatic test_backpressure;
    run_seq(0, 2, 2, 8'h0D, 1'b0, 1'b0);
    data = 8'h55;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      n_vec++;
      if (valid_w[0] !== 1'b1 || vec_w[0] !== 8'h0D || busy_w[0] !== 1'b1 || inta_w[0] !== 1'b1) begin
        n_err++;
        $display("FAIL backpressure k=%0d got valid=%b vec=%h busy=%b inta=%b want 1 0d 1 1",
                 k, valid_w[0], vec_w[0], busy_w[0], inta_w[0]);
      end
    end
    taken = 1'b1;
    @(negedge clock);
    taken = 1'b0;
    n_vec++;
    if (valid_w[0] !== 1'b0 || busy_w[0] !== 1'b0 || vec_w[0] !== 8'h0D) begin
      n_err++;
      $display("FAIL taken_release got valid=%b busy=%b vec=%h want 0 0 0d", valid_w[0], busy_w[0], vec_w[0]);
    end
  endtask

  task automatic test_withdrawn;
    run_seq(0, 2, 2, 8'h0F, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back;
    run_seq(0, 2, 2, 8'h21, 1'b1, 1'b1);
    @(negedge clock);
    req[0] = 1'b0;
    n_vec++;
    if (inta_w[0] !== 1'b0) begin
      n_err++;
      $display("FAIL back_to_back_restart got inta=%b want 0", inta_w[0]);
    end
    repeat (10) @(negedge clock);
    n_vec++;
    if (busy_w[0] !== 1'b0) begin
      n_err++;
      $display("FAIL back_to_back_idle got busy=%b want 0", busy_w[0]);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clock);
    req[0] = 1'b1; enable = 1'b1; boundary = 1'b1; taken = 1'b0; data = 8'h77;
    repeat (5) @(negedge clock);
    req[0] = 1'b0;
    n_vec++;
    if (inta_w[0] !== 1'b0) begin
      n_err++;
      $display("FAIL pre_reset_inta2 got inta=%b want 0", inta_w[0]);
    end
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if (inta_w[0] !== 1'b1 || valid_w[0] !== 1'b0 || vec_w[0] !== 8'h00 || busy_w[0] !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset got inta=%b valid=%b vec=%h busy=%b want 1 0 00 0",
               inta_w[0], valid_w[0], vec_w[0], busy_w[0]);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      n_vec++;
      if (inta_w[0] !== 1'b1 || valid_w[0] !== 1'b0 || busy_w[0] !== 1'b0) begin
        n_err++;
        $display("FAIL post_reset k=%0d got inta=%b valid=%b busy=%b want 1 0 0",
                 k, inta_w[0], valid_w[0], busy_w[0]);
      end
    end
  endtask

  task automatic test_sweep;
    run_seq(1, 1, 1, 8'h3C, 1'b1, 1'b0);
    run_seq(2, 3, 4, 8'hA5, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_gating;
    test_backpressure;
    test_withdrawn;
    test_back_to_back;
    test_reset_mid;
    test_sweep;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/interrupt_acknowledge_sequencer.md
# interrupt_acknowledge_sequencer

CPU-side initiator of the 8259 interrupt acknowledge protocol. It watches the INTR output of the interrupt controller and, when the CPU can accept an interrupt, drives the two-pulse INTA# sequence. It captures the vector byte driven by the controller during the second pulse and hands it to the CPU core through a valid/taken handshake. It sits between the CPU core and the system-bus data path, opposite the controller's request and in-service logic.

## Interface
Parameters:
- INTA_LOW_CYCLES, 2: clock cycles each INTA# pulse is held low; must be ≥1.
- INTA_GAP_CYCLES, 2: clock cycles INTA# is high between the two pulses; must be ≥1.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  reset, asynchronous, active-high.
- interrupt_request  input  1  INTR from the 8259, active-high level.
- interrupt_enable  input  1  CPU IF flag.
- instruction_boundary  input  1  high when the CPU core can take an interrupt this cycle.
- data_bus_in  input  8  bus data; carries the vector during the second INTA# pulse.
- vector_taken  input  1  CPU core accepts the vector.
- interrupt_acknowledge_n  output  1  INTA# to the 8259, active-low.
- vector  output  8  captured interrupt vector.
- vector_valid  output  1  vector holds a captured, unconsumed byte.
- busy  output  1  sequence in progress or vector pending.

## Operation
- States: IDLE, INTA1, GAP, INTA2, HOLD. One down-counter, width clog2(max(INTA_LOW_CYCLES, INTA_GAP_CYCLES)+1), is reloaded on every state entry.
- IDLE: start when interrupt_request & interrupt_enable & instruction_boundary are all high at the edge. Go to INTA1 and load INTA_LOW_CYCLES.
- INTA1: interrupt_acknowledge_n=0. When the counter expires, go to GAP and load INTA_GAP_CYCLES.
- GAP: interrupt_acknowledge_n=1. When the counter expires, go to INTA2 and load INTA_LOW_CYCLES.
- INTA2: interrupt_acknowledge_n=0. At the edge where the counter expires:
  - register data_bus_in into vector;
  - set vector_valid=1;
  - go to HOLD.
- HOLD: interrupt_acknowledge_n=1 and vector_valid=1. When vector_taken=1 at an edge, clear vector_valid and go to IDLE. vector_taken is ignored in every other state.
- Once INTA1 is entered, the sequence always completes, whatever interrupt_request, interrupt_enable or instruction_boundary do. If INTR is withdrawn, the 8259 supplies its spurious vector, and that byte is passed through unchanged.
- No new sequence starts in the same edge that leaves HOLD. From IDLE, the start conditions are re-evaluated at the next edge.
- busy=1 in every state except IDLE.
- vector keeps its last captured value until the next capture. It is not cleared by the handshake.
- Outputs are registered. interrupt_acknowledge_n is glitch-free.

## Timing
- Reset values: interrupt_acknowledge_n=1, vector=8'h00, vector_valid=0, busy=0, state IDLE.
- Reset asserted mid-sequence, including while INTA# is low:
  - interrupt_acknowledge_n goes to 1 asynchronously;
  - the sequence is abandoned;
  - no vector is produced.
- Let E0 be the edge at which the start condition is sampled. Cycle-by-cycle behaviour:
  - interrupt_acknowledge_n is low from E0 to E0+L (L = INTA_LOW_CYCLES);
  - high from E0+L to E0+L+G (G = INTA_GAP_CYCLES);
  - low from E0+L+G to E0+2L+G.
- The vector is sampled at edge E0+2L+G. vector_valid is high from that edge onward. With defaults, this is edge E0+6.
- data_bus_in must be stable at the last rising edge of the second pulse. The 8259 samples INTA# on falling edges, which gives it a half-cycle of setup.
- vector_valid falls at the edge where vector_taken=1 is sampled. If vector_taken is already high when valid rises, valid lasts exactly one cycle.
- The earliest next start is the edge after the HOLD→IDLE edge. Minimum period between sequences is 2L+G+2 cycles.

## Test plan
- Basic sequence, defaults:
  - Stimulus: interrupt_request=1, IF=1, boundary=1; data_bus_in=8'h08 during the second pulse; vector_taken held high.
  - Response: INTA# low for 2 cycles, high for 2, low for 2; vector=8'h08; vector_valid high for exactly 1 cycle at E0+6; busy high for E0..E0+7.
- Gating: interrupt_request=1 with interrupt_enable=0 (or instruction_boundary=0) for 20 cycles → INTA# stays 1 and busy stays 0.
- Backpressure: vector_taken=0 for 10 cycles after capture of 8'h0D → vector_valid and vector=8'h0D stable for all 10 cycles; vector_taken pulse → valid=0 at the next edge and state returns to IDLE.
- Withdrawn request: interrupt_request drops during GAP; bus=8'h0F → both pulses still issued; vector=8'h0F delivered.
- Reset mid-INTA2: assert reset while INTA# is low → INTA# is 1 before the next clock edge; vector_valid=0 and vector=8'h00; no pulses after reset is released until a new start condition.
- Parameter sweep: L=1,G=1 and L=3,G=4 → pulse widths match; vector_valid at E0+3 and E0+10 respectively.
